vm_vend_ctrl: RTL and testbench
===============================

Name: vm_vend_ctrl

Overview:
Transaction sequencer for the vending machine. It accepts coin events, accumulates credit in 5-unit steps, and drives the product dispenser through a req/ack handshake. It then returns change one 5-unit coin at a time through a second req/ack handshake. It sits between the coin slot front-end and the dispense/change mechanisms, and only one transaction owns the mechanisms at a time.

Parameters:
PRICE, 3, product price in coin units (1 unit = 5); legal range 1..14
CREDIT_W, 4, credit register width; must hold PRICE+1
TIMEOUT_CYC, 200, idle cycles in CREDIT before auto-refund (used only with VM_TIMEOUT_EN)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
in  input  2  coin/command event: 00 none, 01 one unit, 10 two units, 11 cancel
vend_ack  input  1  dispenser acknowledge
chg_ack  input  1  change mechanism acknowledge; one unit returned per cycle it is high
out  output  1  one-cycle pulse: product dispensed
vend_req  output  1  level request to dispenser
chg_req  output  1  level request to return one unit per ack
coin_accept  output  1  one-cycle pulse: coin added to credit
coin_reject  output  1  one-cycle pulse: coin arrived while busy; hardware returns it physically
credit  output  CREDIT_W  current credit in units
busy  output  1  high in VEND or CHANGE

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high. On reset every output is 0, credit is 0 and the state is IDLE. Reset mid-transaction aborts it and credit is lost.
- All outputs are registered. An event on `in` at cycle N takes effect at cycle N+1.
- States: IDLE, CREDIT, VEND, CHANGE.
- IDLE or CREDIT, coin 01/10:
  - credit_next = credit + value; coin_accept pulses.
  - If credit_next >= PRICE, go to VEND with vend_req=1 in the same cycle credit updates.
  - Otherwise go to (or stay in) CREDIT.
- Cancel (11):
  - In CREDIT: go to CHANGE (full refund).
  - In IDLE, VEND or CHANGE: ignored.
- VEND:
  - vend_req stays high until vend_ack is sampled high.
  - On ack: vend_req=0, out=1 for one cycle, credit -= PRICE.
  - Remainder > 0: go to CHANGE. Remainder = 0: go to IDLE.
- CHANGE:
  - chg_req is high while credit > 0.
  - Each cycle chg_ack is sampled high, credit decrements by 1.
  - When credit becomes 0, chg_req falls in that same cycle and the state returns to IDLE.
- Coins in VEND or CHANGE: coin_reject pulses and credit is unchanged.
- vend_ack outside VEND and chg_ack outside CHANGE are ignored.
- Arithmetic: max credit is PRICE+1. No overflow is possible for legal PRICE. Credit never goes negative; chg_ack at credit 0 is ignored.

Optional Feature:
VM_TIMEOUT_EN
- Defined: a counter clears on every accepted coin and increments each cycle spent in CREDIT. When it reaches TIMEOUT_CYC, the state goes to CHANGE and the full credit is refunded. The counter is cleared on leaving CREDIT.
- Undefined: no counter is built, and CREDIT waits indefinitely for a coin or cancel.

Decomposition:
- Package vm_pkg holds:
  - coin encoding constants (COIN_NONE, COIN_ONE, COIN_TWO, COIN_CANCEL)
  - state encoding (ST_IDLE, ST_CREDIT, ST_VEND, ST_CHANGE)
  - unit value constant (5)
- Sub-module vm_credit_timer, instantiated only under VM_TIMEOUT_EN. Ports: clock, reset, clr, run, expire.

Test Plan:
1. Reset, then in=01 for three separate cycles -> credit 1,2,3; vend_req high with credit=3. vend_ack one cycle -> out pulse, credit 0, IDLE, chg_req never high.
2. in=10, in=10 -> credit 4 and vend_req. Ack -> out pulse, credit 1, chg_req=1. One chg_ack -> credit 0, chg_req 0, IDLE.
3. in=10, then in=11 -> CHANGE, chg_req=1, no vend_req. Two chg_ack cycles -> credit 2,1,0, then IDLE; out never pulses.
4. Reach VEND, hold vend_ack low, apply in=01 -> coin_reject one-cycle pulse, credit unchanged, vend_req still 1.
5. Assert reset while in CHANGE with credit 2 -> next cycle all outputs 0, credit 0; a later chg_ack is ignored.
6. With VM_TIMEOUT_EN, in=01, then no input for 200 cycles -> chg_req rises on cycle 201 after the coin; one ack -> IDLE. Without the macro -> still in CREDIT, credit 1.

Source files
------------

// File: rtl/vm_pkg.sv
// vm_pkg: coin/command encodings, FSM state type and coin unit value for the vending controller
package vm_pkg;
  localparam logic [1:0] COIN_NONE   = 2'b00;
  localparam logic [1:0] COIN_ONE    = 2'b01;
  localparam logic [1:0] COIN_TWO    = 2'b10;
  localparam logic [1:0] COIN_CANCEL = 2'b11;
  localparam int UNIT_VALUE = 5;
  typedef enum logic [1:0] {ST_IDLE, ST_CREDIT, ST_VEND, ST_CHANGE} state_t;
endpackage

// File: rtl/vm_credit_timer.sv
// vm_credit_timer: counts cycles spent in CREDIT since the last accepted coin, flags expiry
module vm_credit_timer #(
  parameter int TIMEOUT_CYC = 200
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYC + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clock)
    cnt <= (reset || clr || !run) ? '0 : cnt + 1'b1;
  // fires on the cycle whose edge completes the TIMEOUT_CYC-th idle cycle
  assign expire = run && cnt == W'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/vm_vend_ctrl.sv
// vm_vend_ctrl: coin credit / vend / change sequencer; optional idle refund under VM_TIMEOUT_EN
module vm_vend_ctrl
  import vm_pkg::*;
#(
  parameter int PRICE       = 3,
  parameter int CREDIT_W    = 4,
  parameter int TIMEOUT_CYC = 200
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          in,
  input  logic                vend_ack,
  input  logic                chg_ack,
  output logic                out,
  output logic                vend_req,
  output logic                chg_req,
  output logic                coin_accept,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);
  state_t st, st_n;
  logic [CREDIT_W-1:0] credit_n;
  logic vreq_n, creq_n, out_n, acc_n, rej_n, coin, expire;
  assign coin = in == COIN_ONE || in == COIN_TWO;
`ifdef VM_TIMEOUT_EN
  vm_credit_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clock (clock),
    .reset (reset),
    .clr   (coin),
    .run   (st == ST_CREDIT),
    .expire(expire)
  );
`else
  assign expire = 1'b0;
`endif
  always_comb begin
    st_n     = st;
    credit_n = credit;
    vreq_n   = vend_req;
    creq_n   = chg_req;
    out_n    = 1'b0;
    acc_n    = 1'b0;
    rej_n    = 1'b0;
    case (st)
      ST_IDLE, ST_CREDIT: begin
        if (coin) begin
          credit_n = credit + (in == COIN_TWO ? CREDIT_W'(2) : CREDIT_W'(1));
          acc_n    = 1'b1;
          st_n     = credit_n >= CREDIT_W'(PRICE) ? ST_VEND : ST_CREDIT;
          vreq_n   = credit_n >= CREDIT_W'(PRICE);
        end else if (st == ST_CREDIT && (in == COIN_CANCEL || expire)) begin
          st_n   = ST_CHANGE;
          creq_n = 1'b1;
        end
      end
      ST_VEND: begin
        rej_n = coin;
        if (vend_ack) begin
          credit_n = credit - CREDIT_W'(PRICE);
          vreq_n   = 1'b0;
          out_n    = 1'b1;
          creq_n   = credit_n != '0;
          st_n     = credit_n != '0 ? ST_CHANGE : ST_IDLE;
        end
      end
      ST_CHANGE: begin
        rej_n = coin;
        if (chg_ack && credit != '0) begin
          credit_n = credit - 1'b1;
          creq_n   = credit_n != '0;
          st_n     = credit_n != '0 ? ST_CHANGE : ST_IDLE;
        end
      end
      default: st_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      st          <= ST_IDLE;
      credit      <= '0;
      vend_req    <= 1'b0;
      chg_req     <= 1'b0;
      out         <= 1'b0;
      coin_accept <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      st          <= st_n;
      credit      <= credit_n;
      vend_req    <= vreq_n;
      chg_req     <= creq_n;
      out         <= out_n;
      coin_accept <= acc_n;
      coin_reject <= rej_n;
    end
  end
  assign busy = st == ST_VEND || st == ST_CHANGE;
endmodule

// File: tb/tb_vm_vend_ctrl.sv
// tb_vm_vend_ctrl: directed and random stimulus against a transaction-level reference model
module tb_vm_vend_ctrl;
  localparam int PRICE = 3;
  localparam int CW    = 4;
  localparam int TO    = 200;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [1:0] in = 2'b00;
  logic vend_ack = 1'b0, chg_ack = 1'b0;
  logic out, vend_req, chg_req, coin_accept, coin_reject, busy;
  logic [CW-1:0] credit;
  int n_cmp = 0, n_bad = 0;
  int m_credit = 0, m_idle = 0;
  bit m_vend = 0, m_ref = 0, e_out, e_acc, e_rej;

  vm_vend_ctrl #(.PRICE(PRICE), .CREDIT_W(CW), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset(reset), .in(in), .vend_ack(vend_ack), .chg_ack(chg_ack),
    .out(out), .vend_req(vend_req), .chg_req(chg_req), .coin_accept(coin_accept),
    .coin_reject(coin_reject), .credit(credit), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // money-level view: credit held, a vend pending, or a refund in progress
  task automatic model(input logic [1:0] i, input bit va, input bit ca, input bit rs);
    bit coin, waiting;
    coin = i == 2'd1 || i == 2'd2;
    waiting = !m_vend && !m_ref && m_credit > 0;
    {e_out, e_acc, e_rej} = 3'b000;
    if (rs) begin
      m_credit = 0; m_vend = 0; m_ref = 0;
    end else if (m_vend) begin
      e_rej = coin;
      if (va) begin
        m_credit -= PRICE;
        e_out = 1;
        m_vend = 0;
        m_ref = m_credit > 0;
      end
    end else if (m_ref) begin
      e_rej = coin;
      if (ca && m_credit > 0) begin
        m_credit--;
        m_ref = m_credit > 0;
      end
    end else if (coin) begin
      m_credit += int'(i);
      e_acc = 1;
      m_vend = m_credit >= PRICE;
    end else if (i == 2'd3 && m_credit > 0) begin
      m_ref = 1;
    end
`ifdef VM_TIMEOUT_EN
    else if (waiting && m_idle + 1 == TO) begin
      m_ref = 1;
    end
`endif
    m_idle = (waiting && !coin && !rs) ? m_idle + 1 : 0;
  endtask

  task automatic step(input logic [1:0] i, input bit va, input bit ca, input bit rs);
    @(negedge clock);
    in = i; vend_ack = va; chg_ack = ca; reset = rs;
    @(posedge clock);
    model(i, va, ca, rs);
    #1;
    chk("credit", int'(credit), m_credit);
    chk("vend_req", int'(vend_req), int'(m_vend));
    chk("chg_req", int'(chg_req), int'(m_ref));
    chk("out", int'(out), int'(e_out));
    chk("coin_accept", int'(coin_accept), int'(e_acc));
    chk("coin_reject", int'(coin_reject), int'(e_rej));
    chk("busy", int'(busy), int'(m_vend || m_ref));
  endtask

  initial begin
    int r;
    logic [1:0] ri;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("reset_credit", int'(credit), 0);
    // three single coins then vend, no change
    step(1, 0, 0, 0); step(0, 0, 0, 0); step(1, 0, 0, 0); step(0, 0, 0, 0); step(1, 0, 0, 0);
    chk("t1_credit3", int'(credit), 3);
    chk("t1_vreq", int'(vend_req), 1);
    step(0, 1, 0, 0);
    chk("t1_out", int'(out), 1);
    step(0, 0, 0, 0);
    // overpay by one: vend then one unit of change
    step(2, 0, 0, 0); step(2, 0, 0, 0);
    chk("t2_credit4", int'(credit), 4);
    step(0, 1, 0, 0);
    chk("t2_chg_req", int'(chg_req), 1);
    step(0, 0, 1, 0);
    chk("t2_done", int'(credit), 0);
    step(0, 0, 0, 0);
    // cancel refunds two units
    step(2, 0, 0, 0); step(3, 0, 0, 0);
    chk("t3_chg_req", int'(chg_req), 1);
    step(0, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 0);
    chk("t3_credit0", int'(credit), 0);
    // coin while vending is rejected
    step(2, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    chk("t4_reject", int'(coin_reject), 1);
    chk("t4_credit", int'(credit), 3);
    step(0, 1, 0, 0); step(0, 0, 0, 0);
    // reset mid-refund loses credit
    step(2, 0, 0, 0); step(3, 0, 0, 0); step(0, 0, 0, 1); step(0, 0, 1, 0);
    chk("t5_credit", int'(credit), 0);
    // idle in CREDIT for TO cycles
    step(1, 0, 0, 0);
    for (int k = 0; k < TO + 2; k++) step(0, 0, 0, 0);
`ifndef VM_TIMEOUT_EN
    chk("t6_credit", int'(credit), 1);
`endif
    step(3, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0);
    for (int k = 0; k < 4000; k++) begin
      r = $urandom_range(0, 99);
      ri = r < 55 ? 2'd0 : r < 72 ? 2'd1 : r < 89 ? 2'd2 : 2'd3;
      step(ri, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
